// File: rtl/stream_loader_pkg.sv
// Shared constants for the stream loader: default geometry, memory depths
// and the address-width helper used to size the read/write ports.
package stream_loader_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_IMG_H     = 8;
  localparam int DEF_IMG_W     = 8;
  localparam int DEF_IN_CH     = 1;
  localparam int DEF_WGT_DEPTH = 54;
  localparam int DEF_IMG_DEPTH = DEF_IMG_H * DEF_IMG_W * DEF_IN_CH;

  // Address width for a memory of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_IA_W = addr_w(DEF_IMG_DEPTH);
  localparam int DEF_WA_W = addr_w(DEF_WGT_DEPTH);

endpackage

// File: rtl/sl_bank_ram.sv
// Simple dual-port byte memory: one synchronous write port and one read port
// with a registered output. Storage is not reset; only the output register is.
module sl_bank_ram
  import stream_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_IMG_DEPTH,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Store the incoming byte.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; the output register clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_loader.sv
// Stream loader: demultiplexes a byte stream into a weight buffer and a
// ping-pong pair of image banks, and presents completed image banks to a
// consumer in fill order until the consumer releases them.
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IN_CH     = DEF_IN_CH,
  parameter int WGT_DEPTH = DEF_WGT_DEPTH,
  localparam int IMG_DEPTH = IMG_H * IMG_W * IN_CH,
  localparam int IA_W      = addr_w(IMG_DEPTH),
  localparam int WA_W      = addr_w(WGT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              ram_en,
  input  logic [DATA_W-1:0] din,
  output logic              in_ready,
  output logic              wgt_valid,
  output logic              frame_valid,
  output logic              frame_bank,
  input  logic              frame_done,
  input  logic [IA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [WA_W-1:0]   wgt_rd_addr,
  output logic [DATA_W-1:0] wgt_rd_data
);

  logic [WA_W-1:0]   r_wgt_wptr;
  logic              r_wgt_valid;
  logic [IA_W-1:0]   r_img_wptr;
  logic              r_fbank;     // bank currently being filled
  logic              r_pbank;     // oldest full bank, the one presented
  logic [1:0]        r_full;
  logic              r_rd_sel;    // bank whose read data is on the output

  logic              w_wgt_acc;
  logic              w_wgt_last;
  logic              w_img_acc;
  logic              w_img_last;
  logic              w_release;
  logic [1:0]        w_full_nxt;
  logic [DATA_W-1:0] w_rd_bank [2];

  assign w_wgt_acc  = ram_en & mode;
  assign w_wgt_last = (r_wgt_wptr == WA_W'(WGT_DEPTH - 1));
  assign w_img_acc  = ram_en & ~mode & ~r_full[r_fbank];
  assign w_img_last = (r_img_wptr == IA_W'(IMG_DEPTH - 1));
  assign w_release  = frame_done & r_full[r_pbank];

  // Full flags: a release and a completion always target different banks,
  // because the fill bank is never a full bank when a byte is accepted.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release)               w_full_nxt[r_pbank] = 1'b0;
    if (w_img_acc && w_img_last) w_full_nxt[r_fbank] = 1'b1;
  end

  // Weight write pointer and the "full weight set present" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wgt_wptr  <= '0;
      r_wgt_valid <= 1'b0;
    end else if (w_wgt_acc) begin
      r_wgt_wptr <= w_wgt_last ? '0 : r_wgt_wptr + 1'b1;
      if (w_wgt_last)               r_wgt_valid <= 1'b1;
      else if (r_wgt_wptr == '0)    r_wgt_valid <= 1'b0;
    end
  end

  // Image write pointer; switch fill bank at the end of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_img_wptr <= '0;
      r_fbank    <= 1'b0;
    end else if (w_img_acc) begin
      r_img_wptr <= w_img_last ? '0 : r_img_wptr + 1'b1;
      if (w_img_last) r_fbank <= ~r_fbank;
    end
  end

  // Bank ownership: full flags and the presented bank, advanced on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 2'b00;
      r_pbank <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_release) r_pbank <= ~r_pbank;
    end
  end

  // Remember which bank was addressed so the registered data is muxed to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_sel <= 1'b0;
    else     r_rd_sel <= r_pbank;
  end

  for (genvar g = 0; g < 2; g++) begin : g_img_bank
    sl_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_DEPTH),
      .AW     (IA_W)
    ) u_img_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_img_acc && (r_fbank == 1'(g))),
      .i_waddr (r_img_wptr),
      .i_wdata (din),
      .i_raddr (rd_addr),
      .o_rdata (w_rd_bank[g])
    );
  end

  sl_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (WGT_DEPTH),
    .AW     (WA_W)
  ) u_wgt_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wgt_acc),
    .i_waddr (r_wgt_wptr),
    .i_wdata (din),
    .i_raddr (wgt_rd_addr),
    .o_rdata (wgt_rd_data)
  );

  assign in_ready    = ~r_full[r_fbank];
  assign frame_valid = r_full[r_pbank];
  assign frame_bank  = r_pbank;
  assign wgt_valid   = r_wgt_valid;
  assign rd_data     = r_rd_sel ? w_rd_bank[1] : w_rd_bank[0];

endmodule

// File: tb/tb_stream_loader.sv
// Bench for stream_loader: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_stream_loader;

  localparam int IMGD = 64;
  localparam int WGTD = 54;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       ram_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       frame_done = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [5:0] wgt_rd_addr = 6'd0;
  logic       in_ready, wgt_valid, frame_valid, frame_bank;
  logic [7:0] rd_data, wgt_rd_data;

  int checks = 0;
  int failures = 0;
  bit rnd_rd = 1'b0;

  stream_loader dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .ram_en      (ram_en),
    .din         (din),
    .in_ready    (in_ready),
    .wgt_valid   (wgt_valid),
    .frame_valid (frame_valid),
    .frame_bank  (frame_bank),
    .frame_done  (frame_done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wgt_rd_addr (wgt_rd_addr),
    .wgt_rd_data (wgt_rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_img [2][IMGD];
  logic [7:0] m_wgt [WGTD];
  bit         m_wwr [WGTD];
  bit [1:0]   m_full = 2'b00;
  int         m_fb = 0;
  int         m_ip = 0;
  int         m_wp = 0;
  bit         m_wv = 1'b0;
  int         m_q[$];          // full banks, oldest first
  bit         e_rd_ok = 1'b1;
  logic [7:0] e_rd = 8'h00;
  bit         e_wrd_ok = 1'b1;
  logic [7:0] e_wrd = 8'h00;

  initial begin
    for (int i = 0; i < WGTD; i++) m_wwr[i] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 2'b00; m_fb = 0; m_ip = 0; m_wp = 0; m_wv = 1'b0;
      m_q.delete();
      e_rd_ok = 1'b1; e_rd = 8'h00; e_wrd_ok = 1'b1; e_wrd = 8'h00;
    end else begin
      bit acc;
      e_rd_ok = (m_q.size() != 0);
      if (e_rd_ok) e_rd = m_img[m_q[0]][rd_addr];
      e_wrd_ok = (int'(wgt_rd_addr) < WGTD) && m_wwr[wgt_rd_addr];
      if (e_wrd_ok) e_wrd = m_wgt[wgt_rd_addr];
      acc = ram_en && !mode && !m_full[m_fb];
      if (frame_done && m_q.size() != 0) begin
        m_full[m_q[0]] = 1'b0;
        void'(m_q.pop_front());
      end
      if (ram_en && mode) begin
        if (m_wp == 0) m_wv = 1'b0;
        m_wgt[m_wp] = din;
        m_wwr[m_wp] = 1'b1;
        if (m_wp == WGTD - 1) m_wv = 1'b1;
        m_wp = (m_wp + 1) % WGTD;
      end
      if (acc) begin
        m_img[m_fb][m_ip] = din;
        m_ip = m_ip + 1;
        if (m_ip == IMGD) begin
          m_ip = 0;
          m_full[m_fb] = 1'b1;
          m_q.push_back(m_fb);
          m_fb = 1 - m_fb;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_full[m_fb]));
    chk("frame_valid", 32'(frame_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("frame_bank", 32'(frame_bank), 32'(m_q[0]));
    chk("wgt_valid", 32'(wgt_valid), 32'(m_wv));
    if (e_rd_ok)  chk("rd_data", 32'(rd_data), 32'(e_rd));
    if (e_wrd_ok) chk("wgt_rd_data", 32'(wgt_rd_data), 32'(e_wrd));
  end

  // ---------------- stimulus ----------------
  logic [7:0] cur [IMGD];
  logic [7:0] wd  [WGTD];

  task automatic tick(input logic en, input logic md, input logic [7:0] d, input logic fd);
    ram_en = en; mode = md; din = d; frame_done = fd;
    if (rnd_rd) begin
      rd_addr     = 6'($urandom_range(0, 63));
      wgt_rd_addr = 6'($urandom_range(0, 63));
    end
    @(posedge clk); #2;
    ram_en = 1'b0; frame_done = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int start);
    for (int i = start; i < start + n; i++) begin
      cur[i] = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 8'h00, 1'b0);
      tick(1'b1, 1'b0, cur[i], 1'b0);
    end
  endtask

  task automatic send_weights();
    for (int i = 0; i < WGTD; i++) begin
      wd[i] = 8'($urandom);
      tick(1'b1, 1'b1, wd[i], 1'b0);
      if (i == 0)  chk("wgt_valid_first_byte", 32'(wgt_valid), 32'd0);
      if (i == 52) chk("wgt_valid_early", 32'(wgt_valid), 32'd0);
    end
    chk("wgt_valid_loaded", 32'(wgt_valid), 32'd1);
  endtask

  task automatic read_img(input int a);
    rd_addr = 6'(a);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rd_data_lit", 32'(rd_data), 32'(cur[a]));
  endtask

  task automatic reset_lits();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_bank", 32'(frame_bank), 32'd0);
    chk("rst_wgt_valid", 32'(wgt_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wgt_rd_data", 32'(wgt_rd_data), 32'd0);
  endtask

  initial begin
    @(posedge clk); #2;
    reset_lits();
    rst = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);

    // Weight load and full readback with latency 1.
    send_weights();
    for (int i = 0; i < WGTD; i++) begin
      wgt_rd_addr = 6'(i);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      chk("wgt_rd_lit", 32'(wgt_rd_data), 32'(wd[i]));
    end

    // First frame with gaps lands in bank 0.
    send_pixels(IMGD, 0);
    chk("f0_valid", 32'(frame_valid), 32'd1);
    chk("f0_bank", 32'(frame_bank), 32'd0);
    chk("f0_in_ready", 32'(in_ready), 32'd1);
    for (int a = 0; a < IMGD; a += 9) read_img(a);

    // Second frame fills bank 1; both banks now full, extra bytes dropped.
    send_pixels(IMGD, 0);
    chk("both_full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'($urandom), 1'b0);
    chk("drop_bank", 32'(frame_bank), 32'd0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rel0_bank", 32'(frame_bank), 32'd1);
    chk("rel0_in_ready", 32'(in_ready), 32'd1);
    chk("rel0_valid", 32'(frame_valid), 32'd1);
    read_img(3);
    read_img(63);

    // Release bank 1, then release bank 0 on the cycle bank 1 completes.
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("empty_valid", 32'(frame_valid), 32'd0);
    send_pixels(IMGD, 0);
    send_pixels(IMGD - 1, 0);
    chk("pre_sim_bank", 32'(frame_bank), 32'd0);
    cur[IMGD-1] = 8'($urandom);
    tick(1'b1, 1'b0, cur[IMGD-1], 1'b1);
    chk("sim_valid", 32'(frame_valid), 32'd1);
    chk("sim_bank", 32'(frame_bank), 32'd1);
    read_img(IMGD - 1);

    // Weights interleaved mid-frame at pixel 30.
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    send_pixels(30, 0);
    send_weights();
    send_pixels(IMGD - 30, 30);
    chk("mix_valid", 32'(frame_valid), 32'd1);
    chk("mix_bank", 32'(frame_bank), 32'd0);
    read_img(29);
    read_img(30);
    read_img(50);
    wgt_rd_addr = 6'd0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mix_wgt0", 32'(wgt_rd_data), 32'(wd[0]));

    // Reset in the middle of a frame (pixel 40 into bank 1).
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    send_pixels(40, 0);
    rst = 1'b1;
    #1;
    reset_lits();
    @(posedge clk); #2;
    rst = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    send_pixels(IMGD, 0);
    chk("post_rst_valid", 32'(frame_valid), 32'd1);
    chk("post_rst_bank", 32'(frame_bank), 32'd0);
    read_img(39);
    read_img(41);

    // Randomized traffic, checked by the per-cycle comparison.
    rnd_rd = 1'b1;
    repeat (3000) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           8'($urandom), $urandom_range(0, 15) == 0);
    end
    rnd_rd = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_loader.md
STREAM_LOADER -- requirements
Module: stream_loader

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, byte width; IMG_H, 8, image rows; IMG_W, 8, image cols; IN_CH, 1, input channels; WGT_DEPTH, 54, weight bytes per load (K*K*KC*OC).
REQ-002 Derived: IMG_DEPTH = IMG_H*IMG_W*IN_CH; IA_W = clog2(IMG_DEPTH); WA_W = clog2(WGT_DEPTH).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
  - clk  in  1  rising-edge clock.
  - rst  in  1  async active-high reset.
  - mode  in  1  1 = weight byte, 0 = image byte.
  - ram_en  in  1  din valid this cycle.
  - din  in  DATA_W  input byte.
  - in_ready  out  1  loader can accept image byte.
  - wgt_valid  out  1  full weight set loaded.
  - frame_valid  out  1  a full image bank is available to consumer.
  - frame_bank  out  1  index of bank presented.
  - frame_done  in  1  consumer releases presented bank (1-cycle pulse).
  - rd_addr  in  IA_W  image read address in presented bank.
  - rd_data  out  DATA_W  image read data.
  - wgt_rd_addr  in  WA_W  weight read address.
  - wgt_rd_data  out  DATA_W  weight read data.

Function
REQ-005 Byte accepted when ram_en=1 and (mode=1 or in_ready=1); bytes with ram_en=0 ignored; gaps of any length allowed between bytes.
REQ-006 Weight write: accepted byte stored at wgt_wptr; wgt_wptr increments, wraps to 0 after WGT_DEPTH-1.
REQ-007 wgt_valid sets on the cycle after byte WGT_DEPTH-1 is written; clears on first weight byte of a new load; stays set otherwise.
REQ-008 Image storage: two banks of IMG_DEPTH bytes (ping-pong); fill bank fbank, write pointer img_wptr, row-major order.
REQ-009 Accepted image byte written at img_wptr of fbank; on byte IMG_DEPTH-1, bank marked full, img_wptr->0, fbank toggles.
REQ-010 Weight and image pointers independent; a weight byte mid-frame does not disturb img_wptr.
REQ-011 in_ready = 0 iff fill bank is still full (both banks full); combinational from state.
REQ-012 Image byte with ram_en=1, mode=0, in_ready=0 is dropped; no pointer change.
REQ-013 frame_valid=1 while the oldest full bank is unreleased; frame_bank = that bank; banks presented in fill order.
REQ-014 frame_done with frame_valid=1 clears full flag of frame_bank next cycle; frame_done with frame_valid=0 ignored.
REQ-015 Same-cycle frame_done and completion of the other bank: both honoured; frame_valid stays 1, frame_bank toggles next cycle.
REQ-016 Same-cycle frame_done and write into released bank impossible (bank not fill target while full); no bypass required.
REQ-017 rd_data = bank[frame_bank][rd_addr], registered, latency 1 cycle; wgt_rd_data same, latency 1.
REQ-018 rd_addr >= IMG_DEPTH or wgt_rd_addr >= WGT_DEPTH: read data undefined, no state change.

Reset
REQ-019 On rst: wgt_wptr=0, img_wptr=0, fbank=0, both full flags=0, wgt_valid=0, frame_valid=0, frame_bank=0, in_ready=1, rd_data=0, wgt_rd_data=0.
REQ-020 Reset mid-load discards partial weight/image data; memory contents not cleared.

Structure
REQ-021 Shared package holds DATA_W default, IMG/WGT depth constants and derived address widths.
REQ-022 One sub-module, sl_bank_ram (1 write, 1 registered read port), instantiated for each image bank and for weights.

Verification
REQ-023 54 weight bytes mode=1 then read wgt_rd_addr 0..53 -> wgt_valid=1 after byte 53, data match input, latency 1.
REQ-024 64 image bytes with random ram_en gaps -> frame_valid=1, frame_bank=0 after byte 63; rd_data matches.
REQ-025 Send 3 frames without frame_done -> in_ready=0 after 128 bytes; third-frame bytes dropped; frame_done -> frame_bank=1, in_ready=1.
REQ-026 frame_done on same cycle bank 1 completes -> frame_valid stays 1, frame_bank 0->1.
REQ-027 Weight bytes interleaved mid-frame at pixel 30 -> image frame intact, wgt_valid set after 54th weight.
REQ-028 rst asserted at pixel 40 -> all outputs at reset values; next 64 bytes form bank 0 frame.
